// File: rtl/lsu_byte_ctrl.sv
// Byte-serial load/store sequencer: splits B/H/W accesses into byte strobes on a byte-wide memory.
// Latency: store N+1, load N+2, illegal code 1 cycle after acceptance; no new request until after RESP.
module lsu_byte_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  load_code,
    input  logic [1:0]  store_code,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        store_q, store_d;
    logic [2:0]  lcode_q, lcode_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  k_q, k_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic [31:0] data_q, data_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        acc_active;
    logic        dec_legal;
    logic [1:0]  dec_last;

    function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] d);
        case (code)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'h0, d[7:0]};
            3'b101:  extend = {16'h0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // dec_last is the index of the final byte (N-1)
    always_comb begin
        dec_legal = 1'b1;
        dec_last  = 2'd0;
        if (req_is_store) begin
            case (store_code)
                2'b00:   dec_last = 2'd0;
                2'b01:   dec_last = 2'd1;
                2'b10:   dec_last = 2'd3;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            case (load_code)
                3'b000, 3'b100: dec_last = 2'd0;
                3'b001, 3'b101: dec_last = 2'd1;
                3'b010:         dec_last = 2'd3;
                default:        dec_legal = 1'b0;
            endcase
        end
    end

    assign accept     = req_valid && req_ready;
    // Strobes are cut combinationally by rst so an aborted access writes nothing at the reset edge.
    assign acc_active = (state_q == S_ACC) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = dec_legal ? S_ACC : S_RESP;
            S_ACC:   if (k_q == last_q) state_d = store_q ? S_RESP : S_DRAIN;
            S_DRAIN: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE) && !rst;
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
        mem_re     = acc_active && !store_q;
        mem_we     = acc_active && store_q;
        mem_addr   = acc_active ? (addr_q + {30'h0, k_q}) : 32'h0;
        mem_wdata  = acc_active ? wdata_q[{k_q, 3'b000} +: 8] : 8'h0;
    end

    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        store_d      = store_q;
        lcode_d      = lcode_q;
        last_d       = last_q;
        k_d          = k_q;
        rd_pend_d    = 1'b0;
        rd_idx_d     = rd_idx_q;
        data_d       = data_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        if (state_q == S_IDLE && accept) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            store_d = req_is_store;
            lcode_d = load_code;
            last_d  = dec_last;
            k_d     = 2'd0;
            data_d  = 32'h0;
        end

        if (state_q == S_ACC) begin
            k_d       = k_q + 2'd1;
            rd_pend_d = !store_q;
            rd_idx_d  = k_q;
        end

        // Read data arrives one cycle after its strobe
        if (rd_pend_q) begin
            data_d[{rd_idx_q, 3'b000} +: 8] = mem_rdata;
        end

        if (state_d == S_RESP && state_q != S_RESP) begin
            resp_err_d   = (state_q == S_IDLE);
            resp_rdata_d = (state_q == S_DRAIN) ? extend(lcode_q, data_d) : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            store_q      <= 1'b0;
            lcode_q      <= 3'h0;
            last_q       <= 2'd0;
            k_q          <= 2'd0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= 2'd0;
            data_q       <= 32'h0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            store_q      <= store_d;
            lcode_q      <= lcode_d;
            last_q       <= last_d;
            k_q          <= k_d;
            rd_pend_q    <= rd_pend_d;
            rd_idx_q     <= rd_idx_d;
            data_q       <= data_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule
